// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - register-to-register transfer controller for a shared register bus
//
// Purpose: moves one value per request from a source register (or an
// immediate) to a destination register over a shared read bus and a shared
// write bus. Each transfer is a READ cycle, then a WRITE cycle, then a done
// pulse. An out-of-range index is reported with done+err and touches no
// register.
//
// Optional feature macro: BUS_XFER_IMM_EN enables immediate transfers
// (req_imm_en/req_imm). When it is undefined, both inputs are ignored and
// every request is a register transfer.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   request handshake, accepted on valid&ready at posedge
//   req_src, req_dst      source / destination register index
//   req_imm_en, req_imm   immediate select and value
//   out0_en, bus_in       one-hot register read enable and the shared read bus
//   load, bus_out         one-hot register load strobe and the write data
//   done, err             completion pulse and coincident error pulse
//   last_data             value written by the most recent completed transfer
module bus_xfer_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_src,
    input  logic [ADDR_BITS-1:0] req_dst,
    input  logic                 req_imm_en,
    input  logic [DATA_BITS-1:0] req_imm,
    output logic [NUM_REGS-1:0]  out0_en,
    input  logic [DATA_BITS-1:0] bus_in,
    output logic [NUM_REGS-1:0]  load,
    output logic [DATA_BITS-1:0] bus_out,
    output logic                 done,
    output logic                 err,
    output logic [DATA_BITS-1:0] last_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   src_q, src_d;
    logic [ADDR_BITS-1:0]   dst_q, dst_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic [DATA_BITS-1:0]   bus_out_q, bus_out_d;
    logic [DATA_BITS-1:0]   last_data_q, last_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic use_imm;
    logic bad_idx;
    logic accept;

`ifdef BUS_XFER_IMM_EN
    assign use_imm = req_imm_en;
`else
    logic unused_imm;
    assign use_imm    = 1'b0;
    assign unused_imm = ^{req_imm_en, req_imm};
`endif

    // The source index only matters when a register is actually read.
    assign bad_idx = (int'(req_dst) >= NUM_REGS) ||
                     (!use_imm && (int'(req_src) >= NUM_REGS));

    // Gating with reset keeps ready low while reset is held, without a flop.
    assign req_ready = reset && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        hold_d      = hold_q;
        bus_out_d   = bus_out_q;
        last_data_d = last_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (bad_idx) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (use_imm) begin
                        // bus_out is registered, so it is loaded on the edge
                        // that enters WRITE and then holds afterwards.
                        hold_d    = req_imm;
                        bus_out_d = req_imm;
                        state_d   = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                hold_d    = bus_in;
                bus_out_d = bus_in;
                state_d   = WRITE;
            end
            WRITE: begin
                last_data_d = hold_q;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            hold_q      <= '0;
            bus_out_q   <= '0;
            last_data_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            hold_q      <= hold_d;
            bus_out_q   <= bus_out_d;
            last_data_q <= last_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Enables decode straight from the state, so an asynchronous reset
    // clears them at once and READ/WRITE can never overlap.
    assign out0_en   = (state_q == READ)  ? (ONE << src_q) : '0;
    assign load      = (state_q == WRITE) ? (ONE << dst_q) : '0;
    assign bus_out   = bus_out_q;
    assign done      = done_q;
    assign err       = err_q;
    assign last_data = last_data_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - self-checking bench for bus_xfer_ctrl with a behavioural register file
module tb_bus_xfer_ctrl;
    localparam int DW = 8;
    localparam int NR = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_src, req_dst;
    logic          req_imm_en;
    logic [DW-1:0] req_imm;
    logic [NR-1:0] out0_en, load;
    logic [DW-1:0] bus_in, bus_out, last_data;
    logic          done, err;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] mregs[NR];
    logic [DW-1:0] m_last;
    logic          pre_en = 1'b0;
    int            pre_idx = 0;
    logic [DW-1:0] pre_val = '0;

    int total = 0;
    int bad   = 0;

    bus_xfer_ctrl #(.DATA_BITS(DW), .NUM_REGS(NR), .ADDR_BITS(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst),
        .req_imm_en(req_imm_en), .req_imm(req_imm),
        .out0_en(out0_en), .bus_in(bus_in),
        .load(load), .bus_out(bus_out),
        .done(done), .err(err), .last_data(last_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus_in = '0;
        for (int i = 0; i < NR; i++)
            if (out0_en[i]) bus_in = bus_in | regs[i];
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++)
            if (load[i]) regs[i] <= bus_out;
        if (pre_en) regs[pre_idx] <= pre_val;
    end

    task automatic preload(input int idx, input logic [DW-1:0] v);
        pre_idx = idx; pre_val = v; pre_en = 1'b1;
        @(negedge clk); #1;
        pre_en = 1'b0;
        mregs[idx] = v;
    endtask

    task automatic scramble();
        req_src = AW'($urandom); req_dst = AW'($urandom);
        req_imm_en = 1'($urandom); req_imm = DW'($urandom);
    endtask

    // Drives one request and checks every cycle up to one past done.
    task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic ie, input logic [DW-1:0] im);
        logic use_imm, is_bad;
        logic [DW-1:0] val;
        logic [2*NR+1:0] exp_v, got_v;
        int nlat, waitc;
        use_imm = 1'b0;
`ifdef BUS_XFER_IMM_EN
        use_imm = ie;
`endif
        is_bad = (int'(d) >= NR) || (!use_imm && int'(s) >= NR);
        val = use_imm ? im : ((int'(s) < NR) ? mregs[s] : '0);
        nlat = is_bad ? 1 : (use_imm ? 2 : 3);
        @(negedge clk);
        req_valid = 1'b1; req_src = s; req_dst = d; req_imm_en = ie; req_imm = im;
        waitc = 0;
        while (!req_ready && waitc < 10) begin @(negedge clk); waitc++; end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL xfer_ready got=%b want=1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        for (int c = 1; c <= nlat + 1; c++) begin
            exp_v = '0;
            if (c == nlat) exp_v[1:0] = {1'b1, is_bad};
            else if (!is_bad && c == nlat - 1) exp_v[2 +: NR] = NR'(1) << d;
            else if (!is_bad && c < nlat) exp_v[2 + NR +: NR] = NR'(1) << s;
            got_v = {out0_en, load, done, err};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL xfer_cycle%0d s=%0d d=%0d ie=%b got={en=%h ld=%h dn=%b er=%b} want={en=%h ld=%h dn=%b er=%b}",
                         c, s, d, ie, got_v[2+NR +: NR], got_v[2 +: NR], got_v[1], got_v[0],
                         exp_v[2+NR +: NR], exp_v[2 +: NR], exp_v[1], exp_v[0]);
            end
            if (!is_bad && c == nlat - 1) begin
                total++;
                if (bus_out !== val) begin
                    bad++; $display("FAIL xfer_bus_out got=%h want=%h", bus_out, val);
                end
            end
            if (c == nlat) begin
                if (!is_bad) begin
                    mregs[d] = val;
                    m_last = val;
                    total++;
                    if (regs[d] !== mregs[d]) begin
                        bad++; $display("FAIL xfer_reg_dst got=%h want=%h", regs[d], mregs[d]);
                    end
                end
                total++;
                if (last_data !== m_last) begin
                    bad++; $display("FAIL xfer_last_data got=%h want=%h", last_data, m_last);
                end
            end
            if (c <= nlat) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; scramble();
        for (int i = 0; i < NR; i++) preload(i, DW'($urandom));
        total++;
        if ({out0_en, load, done, err, req_ready} !== '0 || bus_out !== '0 || last_data !== '0) begin
            bad++; $display("FAIL reset_state got en=%h ld=%h dn=%b er=%b rdy=%b bo=%h ld=%h want all 0",
                            out0_en, load, done, err, req_ready, bus_out, last_data);
        end
        m_last = '0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_reg_xfer();
        preload(2, 8'h5A);
        run_xfer(3'd2, 3'd5, 1'b0, 8'h00);
        total++;
        if (last_data !== 8'h5A) begin
            bad++; $display("FAIL reg_xfer_last got=%h want=5a", last_data);
        end
    endtask

    task automatic test_imm();
        run_xfer(3'd1, 3'd0, 1'b1, 8'hC3);
    endtask

    task automatic test_bad_index();
        run_xfer(3'd1, 3'd7, 1'b0, 8'h00);
        run_xfer(3'd6, 3'd2, 1'b0, 8'h00);
    endtask

    task automatic test_same_reg();
        preload(3, 8'h11);
        run_xfer(3'd3, 3'd3, 1'b0, 8'h00);
        total++;
        if (regs[3] !== 8'h11) begin
            bad++; $display("FAIL same_reg got=%h want=11", regs[3]);
        end
    endtask

    task automatic test_back_to_back();
        int first_ready;
        logic [DW-1:0] v1;
        preload(1, 8'hA7);
        preload(4, 8'h3C);
        v1 = mregs[1];
        @(negedge clk);
        req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd4; req_imm_en = 1'b0;
        @(posedge clk); #1;
        req_src = 3'd4; req_dst = 3'd0;
        first_ready = 0;
        for (int c = 1; c <= 5 && first_ready == 0; c++) begin
            @(negedge clk);
            total++;
            if ((out0_en & {NR{1'b1}}) != 0 && load != 0) begin
                bad++; $display("FAIL b2b_overlap got en=%h ld=%h want no overlap", out0_en, load);
            end
            if (req_ready) first_ready = c;
        end
        total++;
        if (first_ready != 3) begin
            bad++; $display("FAIL b2b_ready_cycle got=%0d want=3", first_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (out0_en !== 6'b010000 || load !== '0) begin
            bad++; $display("FAIL b2b_second_read got en=%h ld=%h want en=10 ld=0", out0_en, load);
        end
        repeat (3) @(posedge clk); #1;
        mregs[4] = v1; mregs[0] = v1; m_last = v1;
        total++;
        if (regs[0] !== v1 || last_data !== v1) begin
            bad++; $display("FAIL b2b_result got reg0=%h last=%h want=%h", regs[0], last_data, v1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_src = 3'd1; req_dst = 3'd4; req_imm_en = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (out0_en !== 6'b000010) begin
            bad++; $display("FAIL mid_read_en got=%h want=02", out0_en);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({out0_en, load, done, err, req_ready} !== '0 || bus_out !== '0 || last_data !== '0) begin
            bad++; $display("FAIL mid_reset_outputs got en=%h ld=%h dn=%b rdy=%b bo=%h want all 0",
                            out0_en, load, done, req_ready, bus_out);
        end
        m_last = '0;
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (load !== '0 || done !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL mid_after_release c=%0d got ld=%h dn=%b rdy=%b want 0 0 1", c, load, done, req_ready);
            end
        end
        total++;
        if (regs[4] !== mregs[4]) begin
            bad++; $display("FAIL mid_reg_untouched got=%h want=%h", regs[4], mregs[4]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_xfer(AW'($urandom), AW'($urandom_range(0, 6)), 1'($urandom), DW'($urandom));
    endtask

    initial begin
        test_reset();
        test_reg_xfer();
        test_imm();
        test_bad_index();
        test_same_reg();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_BITS, 8, bus and register width
- NUM_REGS, 8, number of registers on the shared bus
- ADDR_BITS, 3, register select width; NUM_REGS <= 2**ADDR_BITS
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; controller state updates on posedge
- reset, in, 1, asynchronous, active-low
- req_valid, in, 1, transfer request
- req_ready, out, 1, request accepted when valid&ready at posedge
- req_src, in, ADDR_BITS, source register index
- req_dst, in, ADDR_BITS, destination register index
- req_imm_en, in, 1, use req_imm instead of a source register
- req_imm, in, DATA_BITS, immediate value
- out0_en, out, NUM_REGS, one-hot read enable to the registers' port-0 outputs
- bus_in, in, DATA_BITS, shared read bus driven by the enabled register
- load, out, NUM_REGS, one-hot load strobe to the registers
- bus_out, out, DATA_BITS, write data to the registers' data_in
- done, out, 1, one-cycle completion pulse
- err, out, 1, one-cycle error pulse, coincident with done
- last_data, out, DATA_BITS, value written by the most recent completed transfer

Function
REQ-003 FSM states SHALL be IDLE, READ and WRITE; req_ready=1 only in IDLE.
REQ-004 IDLE with valid&ready and a register source SHALL go to READ; with req_imm_en=1 it SHALL go to WRITE.
REQ-005 IDLE SHALL latch src, dst, imm_en and imm at acceptance; later request-input changes SHALL have no effect.
REQ-006 READ SHALL assert only out0_en[src] for exactly one cycle and capture bus_in into a hold register at the closing posedge, then go to WRITE.
REQ-007 WRITE SHALL assert only load[dst] and drive bus_out=hold for exactly one cycle; registers capture on the mid-cycle negedge. The FSM SHALL then return to IDLE.
REQ-008 done SHALL pulse in the cycle after WRITE; last_data SHALL update to the hold value at that point.
REQ-009 Latency from the accepting edge to done SHALL be 3 cycles for register transfers and 2 for immediates; the FSM SHALL accept one request per 3 (resp. 2) cycles.
REQ-010 src==dst SHALL be legal and follow the normal READ/WRITE sequence.
REQ-011 If src or dst >= NUM_REGS, the FSM SHALL assert no out0_en or load, skip READ and WRITE, and pulse done and err in the cycle after acceptance.
REQ-012 out0_en and load SHALL never both be nonzero in the same cycle, and each SHALL be at most one-hot.
REQ-013 Outside WRITE, bus_out SHALL hold its last value; outside READ, bus_in SHALL be ignored.

Reset
REQ-014 While reset=0, state SHALL be IDLE and out0_en, load, done and err SHALL be 0, asynchronously.
REQ-015 While reset=0, bus_out, hold and last_data SHALL be 0 and req_ready SHALL be 0.
REQ-016 A reset asserted mid-transfer SHALL abort it: no load strobe and no done after release.
REQ-017 On the first posedge after reset release, req_ready SHALL be 1.

Configuration
REQ-018 Macro BUS_XFER_IMM_EN SHALL control immediate transfers.
- Defined: immediate transfers behave as in REQ-004.
- Undefined: req_imm_en and req_imm are ignored, and every request is a register transfer.

Verification
REQ-019 Preload reg2=0x5A, request src=2, dst=5 -> out0_en=0x04 for 1 cycle, then load=0x20 with bus_out=0x5A; done 3 cycles after acceptance; last_data=0x5A.
REQ-020 With BUS_XFER_IMM_EN, request imm_en=1, imm=0xC3, dst=0 -> no out0_en; load=0x01 with bus_out=0xC3; done after 2 cycles.
REQ-021 NUM_REGS=6, request dst=7 -> out0_en and load stay 0; done=err=1 one cycle after acceptance.
REQ-022 Hold req_valid high for two back-to-back requests -> second is accepted only when req_ready returns to 1; enables never overlap.
REQ-023 Assert reset during READ -> all enables 0 immediately; no load or done after release; req_ready=1 on the next posedge.
REQ-024 src=dst=3 with reg3=0x11 -> reg3 remains 0x11; done pulses once.
